lcd_text_driver: RTL

LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

---
 rtl/lcd_text_driver_if.sv | 13 +
 rtl/lcd_text_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver_if.sv
// rtl/lcd_text_driver_if.sv - HD44780 parallel bus bundle (data, rs, rw, en, power, backlight, frame_done)
interface lcd_text_driver_if;
  logic [7:0] data;
  logic       rs;
  logic       rw;
  logic       en;
  logic       on;
  logic       blon;
  logic       frame_done;

  modport master (output data, rs, rw, en, on, blon, frame_done);
  modport slave  (input  data, rs, rw, en, on, blon, frame_done);
endinterface

// File: rtl/lcd_text_driver.sv
// rtl/lcd_text_driver.sv - HD44780 refresher for a 2x16 text snapshot
// Optional macro LCD_CHANGE_ONLY_EN: redraw only when lcd_text differs from the last drawn frame.
module lcd_text_driver #(
  parameter int EN_CYCLES  = 16,
  parameter int CHAR_WAIT  = 2000,
  parameter int CLEAR_WAIT = 100000,
  parameter int PWRON_WAIT = 750000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [255:0] lcd_text,
  output logic [7:0]   LCD_DATA,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic         LCD_ON,
  output logic         LCD_BLON,
  output logic         frame_done
);

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, FRAME_START, ADDR1, LINE1, ADDR2, LINE2, FRAME_END
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_WAIT} phase_t;

  state_t             state, state_n;
  phase_t             phase, phase_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [4:0]         idx, idx_n;
  logic [255:0]       snapshot, snapshot_n;
  logic [7:0]         char_byte;
  logic [7:0]         cur_byte;
  logic               cur_rs;
  logic [CNT_W-1:0]   phase_last;
  logic               go;
`ifdef LCD_CHANGE_ONLY_EN
  logic               first_frame, first_frame_n;
`endif

  // FRAME_START doubles as the SETUP clock of the 0x80 transaction
  always_comb begin
    char_byte = snapshot[{~idx, 3'b000} +: 8];
    cur_rs    = (state == LINE1) || (state == LINE2);
    cur_byte  = 8'h00;
    case (state)
      INIT: begin
        case (idx[1:0])
          2'd0:    cur_byte = 8'h38;
          2'd1:    cur_byte = 8'h0C;
          2'd2:    cur_byte = 8'h01;
          default: cur_byte = 8'h06;
        endcase
      end
      FRAME_START, ADDR1: cur_byte = 8'h80;
      ADDR2:              cur_byte = 8'hC0;
      LINE1, LINE2:       cur_byte = (char_byte == 8'h00) ? 8'h20 : char_byte;
      default:            cur_byte = 8'h00;
    endcase
    case (phase)
      PH_SETUP:  phase_last = '0;
      PH_STROBE: phase_last = CNT_W'(EN_CYCLES - 1);
      default:   phase_last = (!cur_rs && cur_byte == 8'h01) ? CNT_W'(CLEAR_WAIT - 1)
                                                            : CNT_W'(CHAR_WAIT - 1);
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= PWR_WAIT;
      phase       <= PH_SETUP;
      cnt         <= '0;
      idx         <= '0;
      snapshot    <= '0;
`ifdef LCD_CHANGE_ONLY_EN
      first_frame <= 1'b1;
`endif
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      snapshot    <= snapshot_n;
`ifdef LCD_CHANGE_ONLY_EN
      first_frame <= first_frame_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    idx_n      = idx;
    snapshot_n = snapshot;
`ifdef LCD_CHANGE_ONLY_EN
    first_frame_n = first_frame;
    go            = first_frame || (lcd_text != snapshot);
`else
    go            = 1'b1;
`endif
    case (state)
      PWR_WAIT: begin
        if (cnt == CNT_W'(PWRON_WAIT - 1)) begin
          state_n = INIT;
          phase_n = PH_SETUP;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FRAME_START: begin
        if (go) begin
          state_n    = ADDR1;
          phase_n    = PH_STROBE;
          cnt_n      = '0;
          snapshot_n = lcd_text;
`ifdef LCD_CHANGE_ONLY_EN
          first_frame_n = 1'b0;
`endif
        end
      end
      FRAME_END: begin
        state_n = FRAME_START;
        phase_n = PH_SETUP;
        cnt_n   = '0;
      end
      default: begin
        if (cnt != phase_last) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          cnt_n = '0;
          case (phase)
            PH_SETUP:  phase_n = PH_STROBE;
            PH_STROBE: phase_n = PH_WAIT;
            default: begin
              phase_n = PH_SETUP;
              idx_n   = idx + 5'd1;
              // idx wraps 31 -> 0 by width, ready for the next frame
              case (state)
                INIT:  if (idx[1:0] == 2'd3) begin state_n = FRAME_START; idx_n = '0; end
                ADDR1: begin state_n = LINE1; idx_n = idx; end
                LINE1: if (idx == 5'd15) state_n = ADDR2;
                ADDR2: begin state_n = LINE2; idx_n = idx; end
                LINE2: if (idx == 5'd31) state_n = FRAME_END;
                default: idx_n = idx;
              endcase
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    LCD_DATA   = cur_byte;
    LCD_RS     = cur_rs;
    LCD_RW     = 1'b0;
    LCD_EN     = (phase == PH_STROBE);
    LCD_ON     = 1'b1;
    LCD_BLON   = 1'b1;
    frame_done = (state == FRAME_END);
  end

endmodule
